// File: rtl/ring_decoder_pkg.sv
// Shared definitions for the ring_decoder slice: FSM state type,
// default ring width and the ring rotate-left helper.
package ring_pkg;

  typedef enum logic [1:0] {
    HUNT,
    TRACK,
    LOCKED
  } state_t;

  localparam int unsigned DEFAULT_WIDTH = 4;
  localparam int unsigned MAX_WIDTH     = 64;

  // Rotate the low w bits of v left by one; bits at and above w return 0.
  function automatic logic [MAX_WIDTH-1:0] rotl(input logic [MAX_WIDTH-1:0] v,
                                                input int unsigned w);
    logic [MAX_WIDTH-1:0] r;
    r = '0;
    for (int unsigned i = 1; i < MAX_WIDTH; i++) begin
      if (i < w) r[i] = v[i-1];
    end
    r[0] = v[w-1];
    return r;
  endfunction

endpackage

// File: rtl/ring_decoder_onehot_enc.sv
// Combinational one-hot validator and binary encoder for a ring word.
module onehot_enc
  import ring_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH,
  localparam int unsigned IDX_W = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] word,
  output logic             is_onehot,
  output logic [IDX_W-1:0] idx
);

  // Exactly one bit set; idx is the position of the highest set bit.
  always_comb begin
    is_onehot = (word != '0) && ((word & (word - 1'b1)) == '0);
    idx       = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (word[i]) idx = IDX_W'(i);
    end
  end

endmodule

// File: rtl/ring_decoder.sv
// Receive-side checker for a rotating one-hot ring-counter code.
// Validates one-hot, encodes the index, tracks rotate-left progression,
// locks after LOCK_CNT good steps and counts sequence errors.
// Optional: define RING_DEC_STICKY_ERR_EN to add the err_sticky output.
module ring_decoder
  import ring_pkg::*;
#(
  parameter int unsigned WIDTH     = DEFAULT_WIDTH,
  parameter int unsigned LOCK_CNT  = 3,
  parameter int unsigned ERR_CNT_W = 8,
  localparam int unsigned IDX_W    = $clog2(WIDTH)
) (
  input  logic                 clk,
  input  logic                 set,
  input  logic                 valid_in,
  input  logic [WIDTH-1:0]     ring_in,
  output logic [IDX_W-1:0]     index,
  output logic                 onehot_ok,
  output logic                 locked,
  output logic                 step_err,
  output logic                 wrap,
  output logic [ERR_CNT_W-1:0] err_count
`ifdef RING_DEC_STICKY_ERR_EN
  ,
  output logic                 err_sticky
`endif
);

  localparam int unsigned GOOD_W = $clog2(LOCK_CNT + 1);

  state_t              state, state_n;
  logic [GOOD_W-1:0]   good_cnt, good_cnt_n;
  logic [WIDTH-1:0]    prev, prev_n;
  logic                step_err_n, wrap_n;
  logic [ERR_CNT_W-1:0] err_count_n;

  logic                is_onehot;
  logic [IDX_W-1:0]    enc_idx;
  logic                match;

  onehot_enc #(.WIDTH(WIDTH)) u_enc (
    .word      (ring_in),
    .is_onehot (is_onehot),
    .idx       (enc_idx)
  );

  // Incoming word equals the rotate-left of the previous accepted word.
  always_comb begin
    match = (MAX_WIDTH'(ring_in) == rotl(MAX_WIDTH'(prev), WIDTH));
  end

  // Next-state, tracking counters and pulse outputs.
  always_comb begin
    state_n     = state;
    good_cnt_n  = good_cnt;
    prev_n      = prev;
    step_err_n  = 1'b0;
    wrap_n      = 1'b0;
    err_count_n = err_count;
    if (valid_in) begin
      unique case (state)
        HUNT: begin
          if (is_onehot) begin
            state_n    = TRACK;
            good_cnt_n = GOOD_W'(1);
            prev_n     = ring_in;
          end
        end
        TRACK: begin
          if (match) begin
            prev_n = ring_in;
            if (GOOD_W'(good_cnt + 1'b1) == GOOD_W'(LOCK_CNT)) begin
              state_n    = LOCKED;
              good_cnt_n = '0;
            end else begin
              good_cnt_n = GOOD_W'(good_cnt + 1'b1);
            end
          end else if (is_onehot) begin
            good_cnt_n = GOOD_W'(1);
            prev_n     = ring_in;
          end else begin
            state_n    = HUNT;
            good_cnt_n = '0;
          end
        end
        LOCKED: begin
          if (match) begin
            prev_n = ring_in;
            wrap_n = prev[WIDTH-1];
          end else begin
            step_err_n = 1'b1;
            state_n    = HUNT;
            good_cnt_n = '0;
            if (err_count != '1) err_count_n = err_count + 1'b1;
          end
        end
        default: state_n = HUNT;
      endcase
    end
  end

  // State and output registers; set overrides any valid sample.
  always_ff @(posedge clk) begin
    if (set) begin
      state     <= HUNT;
      good_cnt  <= '0;
      prev      <= '0;
      index     <= '0;
      onehot_ok <= 1'b0;
      locked    <= 1'b0;
      step_err  <= 1'b0;
      wrap      <= 1'b0;
      err_count <= '0;
    end else begin
      state     <= state_n;
      good_cnt  <= good_cnt_n;
      prev      <= prev_n;
      locked    <= (state_n == LOCKED);
      step_err  <= step_err_n;
      wrap      <= wrap_n;
      err_count <= err_count_n;
      if (valid_in) begin
        onehot_ok <= is_onehot;
        if (is_onehot) index <= enc_idx;
      end
    end
  end

`ifdef RING_DEC_STICKY_ERR_EN
  // Sticky error flag: set with any step_err, cleared only by set.
  always_ff @(posedge clk) begin
    if (set)             err_sticky <= 1'b0;
    else if (step_err_n) err_sticky <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_ring_decoder.sv
// Directed self-checking bench for ring_decoder (WIDTH=4, LOCK_CNT=3,
// ERR_CNT_W=2 so saturation is reachable).
module tb_ring_decoder;

  logic       clk = 1'b0;
  logic       set;
  logic       valid_in;
  logic [3:0] ring_in;
  logic [1:0] index;
  logic       onehot_ok;
  logic       locked;
  logic       step_err;
  logic       wrap;
  logic [1:0] err_count;
`ifdef RING_DEC_STICKY_ERR_EN
  logic       err_sticky;
`endif

  int checks   = 0;
  int failures = 0;

  ring_decoder #(.WIDTH(4), .LOCK_CNT(3), .ERR_CNT_W(2)) dut (
    .clk       (clk),
    .set       (set),
    .valid_in  (valid_in),
    .ring_in   (ring_in),
    .index     (index),
    .onehot_ok (onehot_ok),
    .locked    (locked),
    .step_err  (step_err),
    .wrap      (wrap),
    .err_count (err_count)
`ifdef RING_DEC_STICKY_ERR_EN
    ,
    .err_sticky(err_sticky)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Apply one cycle of inputs, then sample #1 after the edge.
  task automatic step(input logic s, input logic v, input logic [3:0] w);
    set = s; valid_in = v; ring_in = w;
    @(posedge clk);
    #1;
  endtask

  // Check the full registered output set.
  task automatic outs(input string tag, input logic [1:0] i, input logic ok,
                      input logic lk, input logic se, input logic wr,
                      input logic [1:0] ec);
    chk({tag, ".index"},     32'(index),     32'(i));
    chk({tag, ".onehot_ok"}, 32'(onehot_ok), 32'(ok));
    chk({tag, ".locked"},    32'(locked),    32'(lk));
    chk({tag, ".step_err"},  32'(step_err),  32'(se));
    chk({tag, ".wrap"},      32'(wrap),      32'(wr));
    chk({tag, ".err_count"}, 32'(err_count), 32'(ec));
  endtask

  initial begin
    set = 1'b1; valid_in = 1'b0; ring_in = '0;

    // Reset with a valid good word present
    step(1, 1, 4'b0001);
    step(1, 1, 4'b0001);
    outs("rst", 2'd0, 0, 0, 0, 0, 2'd0);
`ifdef RING_DEC_STICKY_ERR_EN
    chk("rst.sticky", 32'(err_sticky), 32'd0);
`endif

    // Acquire lock: 1000, 0001, 0010
    step(0, 1, 4'b1000); outs("acq0", 2'd3, 1, 0, 0, 0, 2'd0);
    step(0, 1, 4'b0001); outs("acq1", 2'd0, 1, 0, 0, 0, 2'd0);
    step(0, 1, 4'b0010); outs("acq2", 2'd1, 1, 1, 0, 0, 2'd0);

    // Locked progression with wrap after 1000 -> 0001
    step(0, 1, 4'b0100); outs("lk0", 2'd2, 1, 1, 0, 0, 2'd0);
    step(0, 1, 4'b1000); outs("lk1", 2'd3, 1, 1, 0, 0, 2'd0);
    step(0, 1, 4'b0001); outs("lk2", 2'd0, 1, 1, 0, 1, 2'd0);

    // Idle cycle: pulses drop, everything else holds
    step(0, 0, 4'b1111); outs("idle", 2'd0, 1, 1, 0, 0, 2'd0);

    // Invalid multi-bit word while locked
    step(0, 1, 4'b0011); outs("bad", 2'd0, 0, 0, 1, 0, 2'd1);
    step(0, 0, 4'b0000); outs("bad+1", 2'd0, 0, 0, 0, 0, 2'd1);
`ifdef RING_DEC_STICKY_ERR_EN
    chk("bad.sticky", 32'(err_sticky), 32'd1);
`endif

    // No errors in HUNT: all-zero word stays in HUNT silently
    step(0, 1, 4'b0000); outs("hunt0", 2'd0, 0, 0, 0, 0, 2'd1);

    // TRACK: one-hot mismatch restarts count, lock needs 3 more good samples
    step(0, 1, 4'b0001); outs("trk0", 2'd0, 1, 0, 0, 0, 2'd1);
    step(0, 1, 4'b0100); outs("trk1", 2'd2, 1, 0, 0, 0, 2'd1);
    step(0, 1, 4'b1000); outs("trk2", 2'd3, 1, 0, 0, 0, 2'd1);
    step(0, 1, 4'b0001); outs("trk3", 2'd0, 1, 1, 0, 0, 2'd1);
`ifdef RING_DEC_STICKY_ERR_EN
    chk("relock.sticky", 32'(err_sticky), 32'd1);
`endif

    // Stall while locked at index 1 -> error 2
    step(0, 1, 4'b0010); outs("pre_st", 2'd1, 1, 1, 0, 0, 2'd1);
    step(0, 1, 4'b0010); outs("stall1", 2'd1, 1, 0, 1, 0, 2'd2);

    // TRACK invalid word returns to HUNT
    step(0, 1, 4'b1000); outs("ti0", 2'd3, 1, 0, 0, 0, 2'd2);
    step(0, 1, 4'b0000); outs("ti1", 2'd3, 0, 0, 0, 0, 2'd2);
    step(0, 1, 4'b0001); outs("ti2", 2'd0, 1, 0, 0, 0, 2'd2);
    step(0, 1, 4'b0010); outs("ti3", 2'd1, 1, 0, 0, 0, 2'd2);
    step(0, 1, 4'b0100); outs("ti4", 2'd2, 1, 1, 0, 0, 2'd2);

    // Wrong one-hot while locked -> error 3
    step(0, 1, 4'b0001); outs("wrong", 2'd0, 1, 0, 1, 0, 2'd3);

    // Relock and stall again: counter saturates at 3
    step(0, 1, 4'b1000); step(0, 1, 4'b0001); step(0, 1, 4'b0010);
    outs("relock", 2'd1, 1, 1, 0, 0, 2'd3);
    step(0, 1, 4'b0010); outs("sat", 2'd1, 1, 0, 1, 0, 2'd3);

    // Lock, then set with a valid good word clears everything
    step(0, 1, 4'b0100); step(0, 1, 4'b1000); step(0, 1, 4'b0001);
    outs("lk_final", 2'd0, 1, 1, 0, 0, 2'd3);
    step(1, 1, 4'b0010); outs("set_lock", 2'd0, 0, 0, 0, 0, 2'd0);
`ifdef RING_DEC_STICKY_ERR_EN
    chk("set.sticky", 32'(err_sticky), 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ring_decoder.md
Name: ring_decoder

Overview:
Receive-side checker for the rotating one-hot ring-counter code (pattern 1000 -> 0001 -> 0010 -> 0100 -> 1000 for WIDTH=4).
- Samples a ring word and validates that it is one-hot.
- Converts it to a binary index.
- Tracks rotate-left progression, declares lock after LOCK_CNT consecutive good steps, and flags/counts sequence errors.
- Sits at the consuming end of any ring-counter-driven sequencer link.

Parameters:
- WIDTH, 4: ring word width; min 2.
- LOCK_CNT, 3: consecutive valid in-sequence samples needed to assert locked; min 2.
- ERR_CNT_W, 8: width of the saturating error counter.

Ports:
- clk  in  1  clock; all logic on posedge.
- set  in  1  synchronous active-high reset.
- valid_in  in  1  ring_in is sampled this cycle.
- ring_in  in  WIDTH  received ring word.
- index  out  $clog2(WIDTH)  binary position of the set bit of the last one-hot sample.
- onehot_ok  out  1  last sampled word was one-hot.
- locked  out  1  FSM in LOCKED.
- step_err  out  1  one-cycle pulse on a sequence error while LOCKED.
- wrap  out  1  one-cycle pulse on an in-sequence transition from index WIDTH-1 to 0 while LOCKED.
- err_count  out  ERR_CNT_W  saturating count of step_err pulses.

Behaviour:
- All outputs are registered, with 1-cycle latency from the valid_in sample edge.
- Reset (set=1 at posedge):
  - index=0, onehot_ok=0, locked=0, step_err=0, wrap=0, err_count=0.
  - FSM=HUNT, good_cnt=0, prev=0.
  - set overrides valid_in, including mid-lock.
- valid_in=0:
  - FSM, index, onehot_ok, good_cnt and prev hold.
  - step_err=0, wrap=0.
- One-hot: exactly one bit of ring_in set. All-zero or multi-bit words are invalid; onehot_ok=0 and index holds.
- Expected next word: rotl(prev) = {prev[WIDTH-2:0], prev[WIDTH-1]}.
  - A repeated word (stall) counts as a mismatch.
- FSM transitions on valid_in=1:
  - HUNT:
    - one-hot -> TRACK, good_cnt=1, prev=ring_in.
    - otherwise stay in HUNT.
  - TRACK:
    - ring_in==rotl(prev) -> good_cnt+1, prev=ring_in; when good_cnt+1==LOCK_CNT -> LOCKED and good_cnt clears.
    - one-hot mismatch -> stay in TRACK, good_cnt=1, prev=ring_in.
    - invalid word -> HUNT, good_cnt=0.
  - LOCKED:
    - match -> stay, prev=ring_in; wrap=1 if prev[WIDTH-1] was set.
    - any mismatch or invalid word -> step_err=1, err_count+1 (saturates at all-ones), FSM=HUNT, locked=0 next cycle.
- No step_err is raised in HUNT or TRACK.
- step_err and wrap are mutually exclusive.

Optional Feature:
RING_DEC_STICKY_ERR_EN
- Defined:
  - Adds output err_sticky (1 bit).
  - Set on the same edge that produces any step_err.
  - Cleared only by set.
  - Survives relock.
- Undefined:
  - Port and register absent; all other behaviour identical.

Decomposition:
- Package ring_pkg:
  - FSM state enum {HUNT, TRACK, LOCKED}.
  - Default WIDTH constant.
  - rotl function.
- One combinational sub-module, onehot_enc:
  - Input WIDTH word.
  - Outputs is_onehot and binary idx.
  - Instantiated once.
- FSM, counters and output registers stay in ring_decoder.

Test Plan:
1. set=1 for 2 cycles with valid_in=1 and ring_in=0001 -> all outputs 0, FSM=HUNT.
2. valid_in=1 each cycle with ring_in 1000, 0001, 0010 -> locked=1 one cycle after the 0010 sample; index sequence 3, 0, 1; no step_err.
3. While locked, feed 0100, 1000, 0001 -> index 2, 3, 0; wrap=1 for exactly the cycle after 0001 is sampled; err_count stays 0.
4. While locked, feed 0011 -> onehot_ok=0, index holds, step_err=1 for one cycle, err_count=1, locked=0.
5. Locked at index 1, then feed 0010 again (stall) -> step_err=1, err_count increments, FSM=HUNT. Use ERR_CNT_W=2 and repeat 4 errors -> err_count=3 and stays 3.
6. Locked, then assert set with valid_in=1 and a good word -> next cycle all outputs 0. With RING_DEC_STICKY_ERR_EN after test 4 -> err_sticky=1 until set.
